// File: rtl/aht20_i2c_target.sv
// aht20_i2c_target
// I2C target that emulates an AHT20 humidity/temperature sensor so the AHT20
// controller and an I2C master can be exercised without a physical part.
// Supported commands (written by the master, acted on at STOP):
//   0x71        status read setup (read index back to 0)
//   BE 08 00    init -> calibrated
//   AC 33 00    trigger -> latch samples, busy for MEAS_CYCLES+1 clocks
// A read returns: status, H[19:12], H[11:4], {H[3:0],T[19:16]}, T[15:8],
// T[7:0], CRC, then 0xFF for any further bytes.
//
// Optional build macro: AHT20_CRC_EN
//   defined   : byte 6 is CRC-8 (poly 0x31, init 0xFF) over bytes 0-5,
//               snapshotted when a read begins
//   undefined : byte 6 reads 0xFF and no CRC logic exists
//
// Ports
//   clock        system clock (>= 20x SCL)
//   reset        asynchronous active-high reset
//   SDA          open-drain data; only ever driven 0 or released
//   SCL          bus clock (never stretched)
//   hum_raw_in   20-bit humidity sample, latched at trigger
//   temp_raw_in  20-bit temperature sample, latched at trigger
//   calibrated   status bit 3
//   meas_busy    status bit 7
//   meas_done    one-cycle pulse when the busy countdown expires
//   debug_state  current FSM state
module aht20_i2c_target #(
  parameter logic [6:0] ADDR        = 7'h38,
  parameter int         MEAS_CYCLES = 8000
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         SDA,
  input  logic        SCL,
  input  logic [19:0] hum_raw_in,
  input  logic [19:0] temp_raw_in,
  output logic        calibrated,
  output logic        meas_busy,
  output logic        meas_done,
  output logic [3:0]  debug_state
);

  localparam int CW = $clog2(MEAS_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_WR_BYTE  = 4'd3,
    S_WR_ACK   = 4'd4,
    S_RD_BYTE  = 4'd5,
    S_RD_ACK   = 4'd6,
    S_IGNORE   = 4'd7
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus sampling: 2-FF synchronizers plus one delayed copy for edge detection.
  // Both lines go through identical delay so their relative timing is kept.
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q, scl_s, sda_s;
  logic       scl_rise, scl_fall, start_c, stop_c;

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_t          state, state_n;
  logic            sda_oe, sda_oe_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      rx, rx_n, tx, tx_n;
  logic [2:0]      rd_idx, rd_idx_n, idx_inc;
  logic [2:0]      wr_cnt, wr_cnt_n;     // saturates at 4 (= "more than 3")
  logic            wr_txn, wr_txn_n;     // current transaction addressed us for write
  logic            wr_en;
  logic [2:0][7:0] wbuf;
  logic [19:0]     hum_q, temp_q;
  logic [CW-1:0]   cnt;
  logic [7:0]      status_byte, crc_byte, first_byte, next_byte;
  logic            cmd_stop, cmd_rdz, cmd_cal, cmd_trig;

  // Open drain: never drive a 1.
  assign SDA         = sda_oe ? 1'b0 : 1'bz;
  assign debug_state = state;

  function automatic logic [7:0] pick(input logic [2:0]  idx,
                                      input logic [7:0]  st,
                                      input logic [19:0] h,
                                      input logic [19:0] t,
                                      input logic [7:0]  crc);
    case (idx)
      3'd0:    return st;
      3'd1:    return h[19:12];
      3'd2:    return h[11:4];
      3'd3:    return {h[3:0], t[19:16]};
      3'd4:    return t[15:8];
      3'd5:    return t[7:0];
      3'd6:    return crc;
      default: return 8'hFF;
    endcase
  endfunction

  assign status_byte = {meas_busy, 3'b000, calibrated, 3'b000};
  assign idx_inc     = (rd_idx == 3'd7) ? 3'd7 : rd_idx + 3'd1;
  assign first_byte  = pick(3'd0, status_byte, hum_q, temp_q, crc_byte);
  assign next_byte   = pick(idx_inc, status_byte, hum_q, temp_q, crc_byte);

  // Commands are evaluated on the STOP that closes a write to us, using
  // exactly the bytes captured (the 4th and later bytes only bump wr_cnt).
  assign cmd_stop = stop_c & wr_txn;
  assign cmd_rdz  = cmd_stop && (wr_cnt == 3'd1) && (wbuf[0] == 8'h71);
  assign cmd_cal  = cmd_stop && (wr_cnt == 3'd3) &&
                    (wbuf[0] == 8'hBE) && (wbuf[1] == 8'h08) && (wbuf[2] == 8'h00);
  assign cmd_trig = cmd_stop && (wr_cnt == 3'd3) && !meas_busy &&
                    (wbuf[0] == 8'hAC) && (wbuf[1] == 8'h33) && (wbuf[2] == 8'h00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sda_oe  <= 1'b0;
      bit_cnt <= '0;
      rx      <= '0;
      tx      <= '0;
      rd_idx  <= '0;
      wr_cnt  <= '0;
      wr_txn  <= 1'b0;
    end else begin
      state   <= state_n;
      sda_oe  <= sda_oe_n;
      bit_cnt <= bit_cnt_n;
      rx      <= rx_n;
      tx      <= tx_n;
      rd_idx  <= rd_idx_n;
      wr_cnt  <= wr_cnt_n;
      wr_txn  <= wr_txn_n;
    end
  end

  always_comb begin
    state_n   = state;
    sda_oe_n  = sda_oe;
    bit_cnt_n = bit_cnt;
    rx_n      = rx;
    tx_n      = tx;
    rd_idx_n  = rd_idx;
    wr_cnt_n  = wr_cnt;
    wr_txn_n  = wr_txn;
    wr_en     = 1'b0;

    if (start_c) begin
      state_n   = S_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      wr_cnt_n  = '0;
      wr_txn_n  = 1'b0;
    end else if (stop_c) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      wr_txn_n = 1'b0;
      wr_cnt_n = '0;
      if (cmd_rdz) rd_idx_n = '0;
    end else begin
      case (state)
        S_ADDR, S_WR_BYTE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            rx_n      = {rx[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (state == S_WR_BYTE) begin
              sda_oe_n = 1'b1;
              wr_en    = 1'b1;
              wr_cnt_n = (wr_cnt == 3'd4) ? 3'd4 : wr_cnt + 3'd1;
              state_n  = S_WR_ACK;
            end else if (rx[7:1] == ADDR) begin
              sda_oe_n = 1'b1;
              state_n  = S_ADDR_ACK;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          // The falling edge that ends our ACK also starts bit 7 of a read.
          if (scl_fall) begin
            if (rx[0]) begin
              state_n  = S_RD_BYTE;
              rd_idx_n = '0;
              tx_n     = first_byte;
              sda_oe_n = ~first_byte[7];
            end else begin
              state_n  = S_WR_BYTE;
              sda_oe_n = 1'b0;
              wr_txn_n = 1'b1;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          // tx shifts on the rising edge so tx[7] is always the next bit out.
          if (scl_rise && bit_cnt < 4'd8) begin
            tx_n      = {tx[6:0], 1'b1};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = S_RD_ACK;
            end else begin
              sda_oe_n = ~tx[7];
            end
          end
        end
        S_RD_ACK: begin
          // bit_cnt marks that the master's ACK bit has been sampled.
          if (scl_rise) begin
            rx_n      = {rx[6:0], sda_s};
            bit_cnt_n = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt_n = '0;
            if (!rx[0]) begin
              rd_idx_n = idx_inc;
              tx_n     = next_byte;
              sda_oe_n = ~next_byte[7];
              state_n  = S_RD_BYTE;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        default: ;  // S_IDLE, S_IGNORE: wait for START/STOP
      endcase
    end
  end

  // Write buffer: first three bytes only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbuf <= '0;
    end else if (wr_en && wr_cnt < 3'd3) begin
      wbuf[wr_cnt[1:0]] <= rx;
    end
  end

  // ---------------------------------------------------------------------------
  // Calibration flag, sample latch and busy countdown. A trigger can only be
  // accepted while idle, so it never collides with the expiry branch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      calibrated <= 1'b0;
      meas_busy  <= 1'b0;
      meas_done  <= 1'b0;
      cnt        <= '0;
      hum_q      <= '0;
      temp_q     <= '0;
    end else begin
      meas_done <= 1'b0;
      if (meas_busy) begin
        if (cnt == '0) begin
          meas_busy <= 1'b0;
          meas_done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if (cmd_cal) calibrated <= 1'b1;
      if (cmd_trig) begin
        hum_q     <= hum_raw_in;
        temp_q    <= temp_raw_in;
        meas_busy <= 1'b1;
        cnt       <= CW'(MEAS_CYCLES);
      end
    end
  end

`ifdef AHT20_CRC_EN
  // Snapshot the CRC of bytes 0-5 at the start of every read, so byte 6
  // matches the status byte actually sent in the same transfer.
  logic [7:0] crc_q;
  logic       rd_start;

  function automatic logic [7:0] crc8(input logic [47:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 47; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign rd_start = (state == S_ADDR_ACK) && scl_fall && rx[0] && !start_c && !stop_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         crc_q <= '0;
    else if (rd_start) crc_q <= crc8({status_byte, hum_q, temp_q});
  end

  assign crc_byte = crc_q;
`else
  assign crc_byte = 8'hFF;
`endif

endmodule

// File: tb/tb_aht20_i2c_target.sv
// Testbench for aht20_i2c_target: bit-banged I2C master, a reference model
// of the sensor's register view, and a scoreboard. Stimulus pushes expected
// values; the bus tasks push what they observe; a monitor pairs them up.
module tb_aht20_i2c_target;
  localparam int M = 4000;   // MEAS_CYCLES used for the DUT
  localparam int Q = 100;    // quarter SCL period (10 clocks)

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        scl   = 1'b1;
  logic        m_oe  = 1'b0;
  logic [19:0] hum_raw_in  = '0;
  logic [19:0] temp_raw_in = '0;
  logic        calibrated, meas_busy, meas_done;
  logic [3:0]  debug_state;
  wire         sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_oe ? 1'b0 : 1'bz;

  aht20_i2c_target #(.ADDR(7'h38), .MEAS_CYCLES(M)) dut (
    .clock(clock), .reset(reset), .SDA(sda_bus), .SCL(scl),
    .hum_raw_in(hum_raw_in), .temp_raw_in(temp_raw_in),
    .calibrated(calibrated), .meas_busy(meas_busy), .meas_done(meas_done),
    .debug_state(debug_state)
  );

  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  typedef struct { string name; logic [7:0] val; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  int checks = 0, errors = 0, conflicts = 0;

  task automatic push_exp(input string n, input logic [7:0] v);
    exp_t e;
    e.name = n; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_obs(input logic [7:0] v);
    obs_q.push_back(v);
  endtask

  initial forever begin
    @(negedge clock);
    while (obs_q.size() > 0) begin
      logic [7:0] o;
      exp_t e;
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %02h want nothing", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e.val) begin
          errors++;
          $display("FAIL %s got %02h want %02h", e.name, o, e.val);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit          m_cal = 0, m_busy = 0;
  logic [19:0] m_h = '0, m_t = '0;
  int          m_trigs = 0;

  function automatic logic [7:0] model_crc(input logic [47:0] v);
    logic [7:0] c;
    c = 8'hFF;
    for (int b = 0; b < 6; b++) begin
      c = c ^ v[47-8*b -: 8];
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] model_byte(input int k);
    logic [47:0] v;
    v = {m_busy, 3'b000, m_cal, 3'b000, m_h, m_t};
    if (k < 6) return v[47-8*k -: 8];
`ifdef AHT20_CRC_EN
    if (k == 6) return model_crc(v);
`endif
    return 8'hFF;
  endfunction

  // ---------------- meas_done monitor ----------------
  int done_pulses = 0;
  initial begin
    int cyc = 0, rise = 0;
    bit pb = 0, pd = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (meas_busy && !pb) rise = cyc;
      if (meas_done && !pd) begin
        done_pulses++;
        checks++;
        if (cyc - rise != M + 1) begin
          errors++;
          $display("FAIL done_latency got %0d want %0d", cyc - rise, M + 1);
        end
        checks++;
        if (meas_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done got %b want 0", meas_busy);
        end
      end
      if (meas_done && pd) begin
        checks++; errors++;
        $display("FAIL done_width got >1 cycle want 1");
      end
      pb = meas_busy; pd = meas_done;
    end
  end

  // ---------------- bus master ----------------
  task automatic i2c_start();
    m_oe = 0; #(Q); scl = 1; #(Q); m_oe = 1; #(Q); scl = 0; #(Q);
  endtask

  task automatic i2c_stop();
    m_oe = 1; #(Q); scl = 1; #(Q); m_oe = 0; #(Q);
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; #(Q); scl = 1; #(Q);
    if (b && sda_bus === 1'b0) conflicts++;
    #(Q); scl = 0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    m_oe = 0; #(Q); scl = 1; #(Q); ack = sda_bus; #(Q); scl = 0; #(Q);
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      m_oe = 0; #(Q); scl = 1; #(Q); b = {b[6:0], sda_bus}; #(Q); scl = 0; #(Q);
    end
    m_oe = ~nack; #(Q); scl = 1; #(2*Q); scl = 0; #(Q); m_oe = 0;
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2, input bit stop);
    logic ack;
    logic [7:0] bs [3];
    bit match;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    match = (a == 7'h38);
    conflicts = 0;
    push_exp("addr_ack", {7'b0, !match});
    i2c_start();
    write_byte({a, 1'b0}, ack);
    push_obs({7'b0, ack});
    for (int i = 0; i < n; i++) begin
      push_exp("wr_ack", {7'b0, !match});
      write_byte(bs[i], ack);
      push_obs({7'b0, ack});
    end
    push_exp("no_drive", 8'h00);
    push_obs(conflicts[7:0]);
    if (stop) begin
      i2c_stop();
      if (match && n == 3) begin
        if (b0 == 8'hBE && b1 == 8'h08 && b2 == 8'h00) m_cal = 1;
        else if (b0 == 8'hAC && b1 == 8'h33 && b2 == 8'h00 && !m_busy) begin
          m_busy = 1; m_h = hum_raw_in; m_t = temp_raw_in; m_trigs++;
        end
      end
    end
  endtask

  task automatic do_read(input int n);
    logic ack;
    logic [7:0] b;
    push_exp("rd_addr_ack", 8'h00);
    i2c_start();
    write_byte({7'h38, 1'b1}, ack);
    push_obs({7'b0, ack});
    for (int k = 0; k < n; k++) begin
      push_exp($sformatf("rd_byte%0d", k), model_byte(k));
      read_byte(k == n - 1, b);
      push_obs(b);
    end
    push_exp("rd_release", 8'h01);
    push_obs({7'b0, sda_bus});
    i2c_stop();
  endtask

  task automatic wait_done();
    int n = 0;
    while (meas_busy && n < M + 200) begin @(negedge clock); n++; end
    push_exp("busy_clear", 8'h00);
    push_obs({7'b0, meas_busy});
    m_busy = 0;
  endtask

  task automatic reset_during_ack();
    logic [7:0] a;
    int n = 0;
    a = {7'h38, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    m_oe = 0;
    while (sda_bus !== 1'b0 && n < 20) begin @(negedge clock); n++; end
    push_exp("ack_low", 8'h00); push_obs({7'b0, sda_bus});
    @(posedge clock); #1; reset = 1; #1;
    push_exp("rst_sda", 8'h01);   push_obs({7'b0, sda_bus});
    push_exp("rst_state", 8'h00); push_obs({4'b0, debug_state});
    push_exp("rst_cal", 8'h00);   push_obs({7'b0, calibrated});
    m_cal = 0; m_busy = 0; m_h = '0; m_t = '0;
    #(20); reset = 0;
    i2c_stop();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(1_500_000);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    #(53);
    push_exp("rst_busy", 8'h00);  push_obs({7'b0, meas_busy});
    push_exp("rst_done", 8'h00);  push_obs({7'b0, meas_done});
    push_exp("rst_cal0", 8'h00);  push_obs({7'b0, calibrated});
    push_exp("rst_st0", 8'h00);   push_obs({4'b0, debug_state});
    push_exp("rst_sda0", 8'h01);  push_obs({7'b0, sda_bus});
    reset = 0;
    #(200);

    // status read via 0x71 and repeated START
    do_write(7'h38, 1, 8'h71, 8'h00, 8'h00, 1'b0);
    do_read(1);

    // init
    do_write(7'h38, 3, 8'hBE, 8'h08, 8'h00, 1'b1);
    do_read(1);
    push_exp("cal_out", 8'h01); push_obs({7'b0, calibrated});

    // known measurement
    hum_raw_in = 20'h80000; temp_raw_in = 20'h66666;
    do_write(7'h38, 3, 8'hAC, 8'h33, 8'h00, 1'b1);
    do_read(1);
    wait_done();
    do_read(7);

    // randomized measurements, busy-time reads, ignored triggers, junk writes
    for (int it = 0; it < 5; it++) begin
      hum_raw_in = 20'($urandom); temp_raw_in = 20'($urandom);
      do_write(7'h38, 3, 8'hAC, 8'h33, 8'h00, 1'b1);
      r = $urandom_range(0, 2);
      if (r == 0) do_read($urandom_range(1, 3));
      if (r == 1) begin
        hum_raw_in = 20'($urandom); temp_raw_in = 20'($urandom);
        do_write(7'h38, 3, 8'hAC, 8'h33, 8'h00, 1'b1);
        do_read(2);
      end
      wait_done();
      do_read($urandom_range(1, 9));
      do_write(7'h38, 3, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    end

    // wrong address ignored, then right address acked
    do_write(7'h39, 1, 8'hFF, 8'h00, 8'h00, 1'b1);
    do_write(7'h38, 1, 8'h71, 8'h00, 8'h00, 1'b1);

    // reset while the ACK is being driven
    reset_during_ack();
    do_read(2);

    repeat (50) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (done_pulses != m_trigs) begin
      errors++;
      $display("FAIL done_count got %0d want %0d", done_pulses, m_trigs);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
